instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 83 ++++++++
 tb/tb_instr_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the PC, issues one read per cycle to a
// synchronous instruction memory, and presents the returned word to decode.
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush_ex,
    input  logic [21:0] ex_target,
    input  logic        id_branch_taken,
    input  logic [21:0] id_branch_target,
    input  logic        hlt_ID,
    output logic [21:0] im_addr,
    output logic        im_re,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic [21:0] PC_out,
    output logic        instr_valid,
    output logic        halted
);

    localparam logic RUN    = 1'b0;
    localparam logic HALTED = 1'b1;

    logic        state_reg,   state_next;
    logic [21:0] pc_reg,      pc_next;
    logic [21:0] pc_f_reg,    pc_f_next;
    logic        valid_f_reg, valid_f_next;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pc_f_next    = pc_f_reg;
        valid_f_next = valid_f_reg;
        if (state_reg == RUN) begin
            if (flush_ex) begin
                // A flush wins over everything, including a stall and a halt
                // that sits on the wrong path.
                pc_next      = ex_target;
                valid_f_next = 1'b0;
                if (!stall) begin
                    pc_f_next = pc_reg;
                end
            end else if (!stall) begin
                if (hlt_ID) begin
                    state_next   = HALTED;
                    valid_f_next = 1'b0;
                end else if (id_branch_taken) begin
                    // The fall-through fetch issued this cycle is squashed.
                    pc_next      = id_branch_target;
                    pc_f_next    = pc_reg;
                    valid_f_next = 1'b0;
                end else begin
                    pc_next      = pc_reg + 22'd1;
                    pc_f_next    = pc_reg;
                    valid_f_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            pc_reg      <= 22'd0;
            pc_f_reg    <= 22'd0;
            valid_f_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pc_f_reg    <= pc_f_next;
            valid_f_reg <= valid_f_next;
        end
    end

    // While stalled, re-read the in-flight address so im_rdata keeps the same word.
    assign im_addr     = (state_reg == RUN && stall && !flush_ex) ? pc_f_reg : pc_reg;
    assign im_re       = rst_n && (state_reg == RUN);
    assign instr       = valid_f_reg ? im_rdata : 32'h0;
    assign PC_out      = pc_f_reg;
    assign instr_valid = valid_f_reg;
    assign halted      = (state_reg == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table walks reset release, stall,
// redirects, PC wrap and halt; hand sequences cover asynchronous reset.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush_ex;
    logic [21:0] ex_target;
    logic        id_branch_taken;
    logic [21:0] id_branch_target;
    logic        hlt_ID;
    logic [21:0] im_addr;
    logic        im_re;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic [21:0] PC_out;
    logic        instr_valid;
    logic        halted;

    int checks;
    int failures;

    instr_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush_ex         (flush_ex),
        .ex_target        (ex_target),
        .id_branch_taken  (id_branch_taken),
        .id_branch_target (id_branch_target),
        .hlt_ID           (hlt_ID),
        .im_addr          (im_addr),
        .im_re            (im_re),
        .im_rdata         (im_rdata),
        .instr            (instr),
        .PC_out           (PC_out),
        .instr_valid      (instr_valid),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory with mem[n] = n + 0x100.
    initial im_rdata = 32'h0;
    always @(posedge clk) begin
        if (im_re) begin
            im_rdata <= {10'd0, im_addr} + 32'h100;
        end
    end

    typedef struct {
        logic        stall;
        logic        flush;
        logic [21:0] ex_tgt;
        logic        br;
        logic [21:0] br_tgt;
        logic        hlt;
        logic [21:0] e_addr;
        logic        e_re;
        logic [31:0] e_instr;
        logic [21:0] e_pc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic fl, input logic [21:0] et,
                       input logic br, input logic [21:0] bt, input logic h,
                       input logic [21:0] ea, input logic ere, input logic [31:0] ei,
                       input logic [21:0] ep, input logic ev, input logic eh);
        vec_t v;
        v.stall = st; v.flush = fl; v.ex_tgt = et; v.br = br; v.br_tgt = bt; v.hlt = h;
        v.e_addr = ea; v.e_re = ere; v.e_instr = ei; v.e_pc = ep; v.e_valid = ev;
        v.e_halted = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [21:0] ea, input logic ere,
                           input logic [31:0] ei, input logic [21:0] ep,
                           input logic ev, input logic eh);
        chk({tag, ".im_addr"},     {10'd0, im_addr}, {10'd0, ea});
        chk({tag, ".im_re"},       {31'd0, im_re},   {31'd0, ere});
        chk({tag, ".instr"},       instr,            ei);
        chk({tag, ".PC_out"},      {10'd0, PC_out},  {10'd0, ep});
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, ".halted"},      {31'd0, halted},  {31'd0, eh});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush_ex = 1'b0;
        ex_target = 22'd0;
        id_branch_taken = 1'b0;
        id_branch_target = 22'd0;
        hlt_ID = 1'b0;

        //   st fl ex_tgt     br br_tgt  h  addr       re instr        PC_out     v  hlt
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h0,     1, 32'h0,      22'h0,     0, 0); // before 1st edge
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h1,     1, 32'h100,    22'h0,     1, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h2,     1, 32'h101,    22'h1,     1, 0);
        add(1, 0, 22'h0,     0, 22'h0,  0, 22'h2,     1, 32'h102,    22'h2,     1, 0); // stall x3
        add(1, 0, 22'h0,     0, 22'h0,  0, 22'h2,     1, 32'h102,    22'h2,     1, 0);
        add(1, 0, 22'h0,     0, 22'h0,  0, 22'h2,     1, 32'h102,    22'h2,     1, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h3,     1, 32'h102,    22'h2,     1, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h4,     1, 32'h103,    22'h3,     1, 0);
        add(0, 0, 22'h0,     1, 22'h40, 0, 22'h5,     1, 32'h104,    22'h4,     1, 0); // branch at pc=5
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h40,    1, 32'h0,      22'h5,     0, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h41,    1, 32'h140,    22'h40,    1, 0);
        add(1, 1, 22'h10,    1, 22'h40, 0, 22'h42,    1, 32'h141,    22'h41,    1, 0); // flush+branch+stall
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h10,    1, 32'h0,      22'h41,    0, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h11,    1, 32'h110,    22'h10,    1, 0);
        add(0, 1, 22'h3FFFFE,0, 22'h0,  0, 22'h12,    1, 32'h111,    22'h11,    1, 0); // load wrap point
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h3FFFFE,1, 32'h0,      22'h12,    0, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h3FFFFF,1, 32'h4000FE, 22'h3FFFFE,1, 0);
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h0,     1, 32'h4000FF, 22'h3FFFFF,1, 0);
        add(0, 1, 22'h20,    0, 22'h0,  1, 22'h1,     1, 32'h100,    22'h0,     1, 0); // halt + flush
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h20,    1, 32'h0,      22'h1,     0, 0);
        add(1, 0, 22'h0,     0, 22'h0,  1, 22'h20,    1, 32'h120,    22'h20,    1, 0); // halt deferred
        add(0, 0, 22'h0,     0, 22'h0,  1, 22'h21,    1, 32'h120,    22'h20,    1, 0); // halt taken
        add(1, 1, 22'h30,    1, 22'h30, 1, 22'h21,    0, 32'h0,      22'h20,    0, 1); // ignored
        add(0, 0, 22'h0,     0, 22'h0,  0, 22'h21,    0, 32'h0,      22'h20,    0, 1);

        #12;
        chk_all("reset", 22'h0, 1'b0, 32'h0, 22'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            stall = vecs[i].stall;
            flush_ex = vecs[i].flush;
            ex_target = vecs[i].ex_tgt;
            id_branch_taken = vecs[i].br;
            id_branch_target = vecs[i].br_tgt;
            hlt_ID = vecs[i].hlt;
            #1;
            $display("vec %0d: addr=%0h re=%0b instr=%0h pc=%0h v=%0b h=%0b",
                     i, im_addr, im_re, instr, PC_out, instr_valid, halted);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_re, vecs[i].e_instr,
                    vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted);
        end

        // Reset from HALTED, asserted mid-cycle: effect must be immediate.
        @(negedge clk);
        stall = 1'b1;
        flush_ex = 1'b0;
        id_branch_taken = 1'b0;
        hlt_ID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("async reset from halted: halted=%0b re=%0b", halted, im_re);
        chk_all("rst_halted", 22'h0, 1'b0, 32'h0, 22'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
        chk_all("rel0", 22'h0, 1'b1, 32'h0, 22'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk_all("rel1", 22'h1, 1'b1, 32'h100, 22'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk_all("rel2", 22'h2, 1'b1, 32'h101, 22'h1, 1'b1, 1'b0);

        // Reset asserted in the middle of a stall.
        @(negedge clk);
        stall = 1'b1;
        #1;
        chk_all("stall_pre", 22'h2, 1'b1, 32'h102, 22'h2, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-stall: pc_out=%0h valid=%0b", PC_out, instr_valid);
        chk_all("rst_stall", 22'h0, 1'b0, 32'h0, 22'h0, 1'b0, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
